// File: rtl/gtxe2_chnl_tx_oob_seq.sv
// SATA/SAS out-of-band burst sequencer: 10b-encoded ALIGN bursts separated by electrical-idle gaps.
// COMSAS support is compiled in only when GTXE2_OOB_COMSAS_EN is defined.
module gtxe2_chnl_tx_oob_seq #(
   parameter int unsigned WIDTH       = 20,
   parameter int unsigned BURST_NUM   = 6,
   parameter int unsigned BURST_UI    = 160,
   parameter int unsigned INIT_GAP_UI = 480,
   parameter int unsigned WAKE_GAP_UI = 160,
   parameter int unsigned SAS_GAP_UI  = 1440
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cominit,
   input  logic             comwake,
   input  logic             comsas,
   input  logic             disparity,
   output logic [WIDTH-1:0] outdata,
   output logic             outval,
   output logic             idle,
   output logic             busy,
   output logic             TXCOMFINISH
);

`ifdef GTXE2_OOB_COMSAS_EN
   localparam bit SAS_EN = 1'b1;
`else
   localparam bit SAS_EN = 1'b0;
`endif

   localparam int unsigned BURST_WORDS = BURST_UI / WIDTH;
   localparam int unsigned INIT_WORDS  = INIT_GAP_UI / WIDTH;
   localparam int unsigned WAKE_WORDS  = WAKE_GAP_UI / WIDTH;
   localparam int unsigned SAS_WORDS   = SAS_GAP_UI / WIDTH;

   localparam int unsigned MAX_A     = (BURST_WORDS > INIT_WORDS) ? BURST_WORDS : INIT_WORDS;
   localparam int unsigned MAX_B     = (MAX_A > WAKE_WORDS) ? MAX_A : WAKE_WORDS;
   localparam int unsigned MAX_WORDS = (SAS_EN && (SAS_WORDS > MAX_B)) ? SAS_WORDS : MAX_B;
   localparam int unsigned CNT_W     = $clog2(MAX_WORDS) + 1;
   localparam int unsigned BCNT_W    = $clog2(BURST_NUM) + 1;

   localparam bit PARAM_OK = ((WIDTH == 20) || (WIDTH == 40))
      && (BURST_NUM >= 1) && (BURST_NUM <= 15)
      && (BURST_UI > 0) && (BURST_UI % WIDTH == 0) && (BURST_UI % 40 == 0)
      && (INIT_GAP_UI > 0) && (INIT_GAP_UI % WIDTH == 0)
      && (WAKE_GAP_UI > 0) && (WAKE_GAP_UI % WIDTH == 0)
      && (!SAS_EN || ((SAS_GAP_UI > 0) && (SAS_GAP_UI % WIDTH == 0)));

   if (!PARAM_OK) begin : g_param_check
      $fatal(1, "gtxe2_chnl_tx_oob_seq: unsupported parameter set");
   end

   localparam logic [9:0] K28_5_RDN = 10'b0011111010;
   localparam logic [9:0] K28_5_RDP = 10'b1100000101;
   localparam logic [9:0] D10_2     = 10'b0101010101;
   localparam logic [9:0] D27_3_RDN = 10'b1101100011;
   localparam logic [9:0] D27_3_RDP = 10'b0010011100;

   typedef enum logic [1:0] {StIdle, StBurst, StGap, StFinish} state_e;
   typedef enum logic [1:0] {TyInit, TyWake, TySas} seq_e;

   state_e            r_state, w_state_d;
   seq_e              r_type, w_type_d;
   logic              r_disp, w_disp_d;
   logic [CNT_W-1:0]  r_cnt, w_cnt_d, w_gap_last;
   logic [BCNT_W-1:0] r_bcnt, w_bcnt_d;
   logic              w_sas_req;
   logic [39:0]       w_align;
   logic [WIDTH-1:0]  w_word;

   assign w_sas_req = SAS_EN & comsas;

   always_comb begin
      case (r_type)
         TyWake:  w_gap_last = CNT_W'(WAKE_WORDS - 1);
         TySas:   w_gap_last = CNT_W'(SAS_WORDS - 1);
         default: w_gap_last = CNT_W'(INIT_WORDS - 1);
      endcase
   end

   always_comb begin
      w_state_d = r_state;
      w_type_d  = r_type;
      w_disp_d  = r_disp;
      w_cnt_d   = r_cnt;
      w_bcnt_d  = r_bcnt;
      case (r_state)
         StIdle: begin
            if (cominit || comwake || w_sas_req) begin
               w_state_d = StBurst;
               w_type_d  = cominit ? TyInit : (comwake ? TyWake : TySas);
               w_disp_d  = disparity;
               w_cnt_d   = '0;
               w_bcnt_d  = '0;
            end
         end
         StBurst: begin
            if (r_cnt == CNT_W'(BURST_WORDS - 1)) begin
               w_state_d = StGap;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         StGap: begin
            if (r_cnt == w_gap_last) begin
               w_cnt_d = '0;
               if (r_bcnt == BCNT_W'(BURST_NUM - 1)) begin
                  w_state_d = StFinish;
               end else begin
                  w_state_d = StBurst;
                  w_bcnt_d  = r_bcnt + 1'b1;
               end
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Disparity returns to its start value at every ALIGN boundary, so only the start value matters.
   assign w_align = {w_disp_d ? D27_3_RDN : D27_3_RDP, D10_2, D10_2,
                     w_disp_d ? K28_5_RDP : K28_5_RDN};

   if (WIDTH == 40) begin : g_w40
      assign w_word = w_align;
   end else begin : g_w20
      assign w_word = w_cnt_d[0] ? w_align[39:20] : w_align[19:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_type      <= TyInit;
         r_disp      <= 1'b0;
         r_cnt       <= '0;
         r_bcnt      <= '0;
         outdata     <= '0;
         outval      <= 1'b0;
         idle        <= 1'b0;
         busy        <= 1'b0;
         TXCOMFINISH <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_type      <= w_type_d;
         r_disp      <= w_disp_d;
         r_cnt       <= w_cnt_d;
         r_bcnt      <= w_bcnt_d;
         outdata     <= (w_state_d == StBurst) ? w_word : '0;
         outval      <= (w_state_d == StBurst);
         idle        <= (w_state_d == StGap);
         busy        <= (w_state_d == StBurst) || (w_state_d == StGap);
         TXCOMFINISH <= (w_state_d == StFinish);
      end
   end

endmodule

// File: tb/tb_gtxe2_chnl_tx_oob_seq.sv
// Table-driven bench for gtxe2_chnl_tx_oob_seq: default instance plus a WIDTH=40, BURST_NUM=2 one.
module tb_gtxe2_chnl_tx_oob_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        a_init, a_wake, a_sas, a_disp;
   logic [19:0] a_data;
   logic        a_val, a_idle, a_busy, a_fin;
   logic        b_init, b_wake, b_sas, b_disp;
   logic [39:0] b_data;
   logic        b_val, b_idle, b_busy, b_fin;

   int n_cmp;
   int n_err;

   gtxe2_chnl_tx_oob_seq u_dut_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .cominit    (a_init),
      .comwake    (a_wake),
      .comsas     (a_sas),
      .disparity  (a_disp),
      .outdata    (a_data),
      .outval     (a_val),
      .idle       (a_idle),
      .busy       (a_busy),
      .TXCOMFINISH(a_fin)
   );

   gtxe2_chnl_tx_oob_seq #(
      .WIDTH    (40),
      .BURST_NUM(2)
   ) u_dut_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .cominit    (b_init),
      .comwake    (b_wake),
      .comsas     (b_sas),
      .disparity  (b_disp),
      .outdata    (b_data),
      .outval     (b_val),
      .idle       (b_idle),
      .busy       (b_busy),
      .TXCOMFINISH(b_fin)
   );

   typedef struct {
      int          dut;
      logic        init;
      logic        wake;
      logic        sas;
      logic        disp;
      int          mid_wake;
      logic [39:0] w0;
      logic [39:0] w1;
      int          nb;
      int          gap;
      int          fin;
      bit          none;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int dut, input logic i, input logic w, input logic s, input logic d,
                      input int mid, input logic [39:0] w0, input logic [39:0] w1, input int nb,
                      input int gap, input int fin, input bit none);
      vec_t v;
      v.dut = dut; v.init = i; v.wake = w; v.sas = s; v.disp = d; v.mid_wake = mid;
      v.w0 = w0; v.w1 = w1; v.nb = nb; v.gap = gap; v.fin = fin; v.none = none;
      vecs.push_back(v);
   endtask

   task automatic check(input string what, input int cyc, input logic [39:0] got,
                        input logic [39:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc %0d: got %h want %h", what, cyc, got, exp);
      end
   endtask

   task automatic drive(input int dut, input logic i, input logic w, input logic s, input logic d);
      if (dut == 0) begin
         a_init = i; a_wake = w; a_sas = s; a_disp = d;
      end else begin
         b_init = i; b_wake = w; b_sas = s; b_disp = d;
      end
   endtask

   function automatic logic [39:0] flags(input int dut);
      if (dut == 0) return {36'd0, a_val, a_idle, a_busy, a_fin};
      return {36'd0, b_val, b_idle, b_busy, b_fin};
   endfunction

   function automatic logic [39:0] data(input int dut);
      if (dut == 0) return {20'd0, a_data};
      return b_data;
   endfunction

   // Flags are packed {outval, idle, busy, TXCOMFINISH}.
   task automatic run_seq(input int idx);
      vec_t v;
      int last;
      int period;
      int k;
      logic [39:0] ef;
      logic [39:0] ed;
      v = vecs[idx];
      last   = v.none ? 10 : v.fin + 1;
      period = v.nb + v.gap;
      @(posedge clk);
      #1;
      drive(v.dut, v.init, v.wake, v.sas, v.disp);
      @(posedge clk);
      #1;
      drive(v.dut, 1'b0, 1'b0, 1'b0, ~v.disp);
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         ef = '0;
         ed = '0;
         if (!v.none && c < v.fin) begin
            k = (c - 1) % period;
            if (k < v.nb) begin
               ef = 40'b1010;
               ed = (k % 2 == 0) ? v.w0 : v.w1;
            end else begin
               ef = 40'b0110;
            end
         end else if (!v.none && c == v.fin) begin
            ef = 40'b0001;
         end
         check($sformatf("vec%0d flags", idx), c, flags(v.dut), ef);
         check($sformatf("vec%0d data", idx), c, data(v.dut), ed);
         if (v.mid_wake != 0 && c == v.mid_wake) drive(v.dut, 1'b0, 1'b1, 1'b0, ~v.disp);
         if (v.mid_wake != 0 && c == v.mid_wake + 1) drive(v.dut, 1'b0, 1'b0, 1'b0, ~v.disp);
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      reset_n = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0, 1'b0);

      add(0, 1, 0, 0, 0, 0,  40'h554FA, 40'h27155, 8, 24, 193, 0);
      add(0, 0, 1, 0, 1, 0,  40'h55705, 40'hD8D55, 8, 8, 97, 0);
      add(0, 1, 1, 0, 0, 50, 40'h554FA, 40'h27155, 8, 24, 193, 0);
      add(0, 0, 1, 0, 0, 0,  40'h554FA, 40'h27155, 8, 8, 97, 0);
      add(0, 1, 0, 0, 1, 0,  40'h55705, 40'hD8D55, 8, 24, 193, 0);
`ifdef GTXE2_OOB_COMSAS_EN
      add(0, 0, 0, 1, 0, 0,  40'h554FA, 40'h27155, 8, 72, 481, 0);
`else
      add(0, 0, 0, 1, 0, 0,  40'h0, 40'h0, 8, 72, 481, 1);
`endif
      add(0, 0, 1, 1, 1, 0,  40'h55705, 40'hD8D55, 8, 8, 97, 0);
      add(1, 1, 0, 0, 0, 0,  40'h27155554FA, 40'h27155554FA, 4, 12, 33, 0);
      add(1, 0, 1, 0, 1, 0,  40'hD8D5555705, 40'hD8D5555705, 4, 4, 17, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset flags a", 0, flags(0), 40'd0);
      check("reset data a", 0, data(0), 40'd0);
      check("reset flags b", 0, flags(1), 40'd0);
      check("reset data b", 0, data(1), 40'd0);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) run_seq(i);

      // Reset asserted mid-way through the third burst must clear outputs without a clock edge.
      @(posedge clk);
      #1;
      drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 67; c++) @(negedge clk);
      check("pre-reset flags", 67, flags(0), 40'b1010);
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset flags", 67, flags(0), 40'd0);
      check("async reset data", 67, data(0), 40'd0);
      @(negedge clk);
      check("held reset flags", 68, flags(0), 40'd0);
      reset_n = 1'b1;
      run_seq(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
